// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane/plane geometry, engine states and
// lane-index helpers used by the theta engine and the round core.
package keccak_pkg;

  localparam int NUM_LANES = 25;
  localparam int PLANE_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    OUT,
    DONE
  } state_e;

  function automatic logic [2:0] lane_x(input logic [4:0] k);
    return 3'(k % 5'd5);
  endfunction

  function automatic logic [2:0] lane_y(input logic [4:0] k);
    return 3'(k / 5'd5);
  endfunction

  function automatic int prev_x(input int x);
    return (x + PLANE_W - 1) % PLANE_W;
  endfunction

  function automatic int next_x(input int x);
    return (x + 1) % PLANE_W;
  endfunction

endpackage

// File: rtl/theta_d_calc.sv
// Combinational theta D-vector: D[x] = C[x-1] ^ rotl(C[x+1], 1), with
// column indices wrapping modulo 5. Shared with the full round core.
module theta_d_calc
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] c_i [PLANE_W],
  output logic [LANE_W-1:0] d_o [PLANE_W]
);

  for (genvar x = 0; x < PLANE_W; x++) begin : g_col
    localparam int XP = prev_x(x);
    localparam int XN = next_x(x);
    assign d_o[x] = c_i[XP] ^ {c_i[XN][LANE_W-2:0], c_i[XN][LANE_W-1]};
  end

endmodule

// File: rtl/theta_engine.sv
// Streaming Keccak theta engine: loads 25 lanes while accumulating column
// parities, computes D in one cycle, then streams A^D or the 5 parities.
module theta_engine
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [4:0]        k_q, k_d;
  logic              mode_q, mode_d;
  logic [2:0]        k_x;
  logic              last_out;
  logic              load_xfer;
  logic [LANE_W-1:0] c_q     [PLANE_W];
  logic [LANE_W-1:0] d_q     [PLANE_W];
  logic [LANE_W-1:0] d_calc  [PLANE_W];
  logic [LANE_W-1:0] store_q [NUM_LANES];

  assign k_x       = lane_x(k_q);
  assign load_xfer = (state_q == LOAD) && in_valid;
  assign last_out  = mode_q ? (k_q == 5'd4) : (k_q == 5'd24);

  theta_d_calc #(.LANE_W(LANE_W)) u_d_calc (
    .c_i (c_q),
    .d_o (d_calc)
  );

  // Control registers: state, lane counter and the mode latched at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; the counter stops at the last lane and resets in CALC.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          k_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (k_q == 5'd24) begin
            state_d = CALC;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      CALC: begin
        k_d     = '0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (last_out) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: lane store, running column parities and the registered D vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) store_q[i] <= '0;
      for (int x = 0; x < PLANE_W; x++) begin
        c_q[x] <= '0;
        d_q[x] <= '0;
      end
    end else begin
      if ((state_q == IDLE) && start) begin
        for (int x = 0; x < PLANE_W; x++) c_q[x] <= '0;
      end else if (load_xfer) begin
        store_q[k_q] <= in_lane;
        c_q[k_x]     <= c_q[k_x] ^ in_lane;
      end
      if (state_q == CALC) begin
        d_q <= d_calc;
      end
    end
  end

  // Output lane selection; held stable while stalled because k only moves on a transfer.
  always_comb begin
    out_lane = '0;
    if (state_q == OUT) begin
      if (mode_q) begin
        out_lane = c_q[k_q[2:0]];
      end else begin
        out_lane = store_q[k_q] ^ d_q[k_x];
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
